// File: rtl/serial_pkg.sv
// Shared types and defaults for the bit-serial operand/result path.
// Also used by the result deserializer.
package serial_pkg;

    localparam int SER_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH
    } ser_state_e;

endpackage

// File: rtl/piso_reg.sv
// Parallel-load, shift-right register with an LSB tap.
// Zeros shift in from the top, so an emptied register taps 0.
module piso_reg
    import serial_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         lsb_o
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    // Load has priority over shift.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = d_i;
        end else if (shift_i) begin
            sh_d = {1'b0, sh_q[W-1:1]};
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign lsb_o = sh_q[0];

endmodule

// File: rtl/operand_serializer.sv
// Serialises W-bit operand pairs LSB-first for the serial adder,
// one flush cycle (a=b=0) after every word, one word in reserve.
module operand_serializer
    import serial_pkg::*;
#(
    parameter int W = SER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         first,
    output logic         flush,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    ser_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_v_q, pend_v_d;
    logic [W-1:0]  pend_a_q, pend_b_q;
    logic          load, shift, take;
    logic          bv_q, bv_d;
    logic          first_q, first_d;
    logic          flush_q, flush_d;
    logic          busy_q, busy_d;

    assign in_ready = !rst && !pend_v_q;
    assign take     = in_valid && in_ready;

    // Next state, counter and shift control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                if (pend_v_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs follow the state being entered.
    always_comb begin
        pend_v_d = take || (pend_v_q && !load);
        bv_d     = (state_d == SHIFT);
        first_d  = (state_d == SHIFT) && (cnt_d == '0);
        flush_d  = (state_d == FLUSH);
        busy_d   = (state_d != IDLE);
    end

    // FSM, counter, pending flag and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_v_q <= 1'b0;
            bv_q     <= 1'b0;
            first_q  <= 1'b0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_v_q <= pend_v_d;
            bv_q     <= bv_d;
            first_q  <= first_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
        end
    end

    // Pending operand pair, written on each accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a_q <= '0;
            pend_b_q <= '0;
        end else if (take) begin
            pend_a_q <= op_a;
            pend_b_q <= op_b;
        end
    end

    piso_reg #(.W(W)) u_sh_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (pend_a_q),
        .lsb_o   (a)
    );

    piso_reg #(.W(W)) u_sh_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (pend_b_q),
        .lsb_o   (b)
    );

    assign bit_valid = bv_q;
    assign first     = first_q;
    assign flush     = flush_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: word-position model plus a
// behavioural serial adder consuming the DUT bit stream.
module tb_operand_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         a, b, bit_valid, first, flush, busy;

    always #5 clk = ~clk;

    operand_serializer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .a         (a),
        .b         (b),
        .bit_valid (bit_valid),
        .first     (first),
        .flush     (flush),
        .busy      (busy)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: m_act = position in the active word
    // (-1 idle, 0..W-1 bit index, W flush cycle).
    bit           m_pend = 1'b0;
    bit           m_took = 1'b0;
    logic [W-1:0] m_pa = '0, m_pb = '0;
    logic [W-1:0] m_wa = '0, m_wb = '0;
    int           m_act = -1;
    logic [W:0]   sumq[$];

    // Serial adder attached to the DUT outputs.
    logic         c = 1'b0;
    logic [W:0]   res = '0;
    int           idx = 0;

    int busy_n = 0;
    int bv_n   = 0;

    task automatic model_edge(input bit r, input bit v,
                              input logic [W-1:0] xa,
                              input logic [W-1:0] xb);
        bit tk;
        tk = v && !r && !m_pend;
        m_took = tk;
        if (r) begin
            m_pend = 1'b0;
            m_act  = -1;
            sumq.delete();
            c   = 1'b0;
            idx = 0;
            res = '0;
            return;
        end
        if (m_act >= 0 && m_act < W) begin
            m_act++;
        end else if (m_pend) begin
            m_act  = 0;
            m_wa   = m_pa;
            m_wb   = m_pb;
            m_pend = 1'b0;
            sumq.push_back({1'b0, m_pa} + {1'b0, m_pb});
        end else begin
            m_act = -1;
        end
        if (tk) begin
            m_pend = 1'b1;
            m_pa   = xa;
            m_pb   = xb;
        end
    endtask

    task automatic compare();
        logic ev, ea, eb;
        logic [6:0] got, exp;
        ev = (m_act >= 0 && m_act < W);
        ea = ev ? m_wa[m_act] : 1'b0;
        eb = ev ? m_wb[m_act] : 1'b0;
        exp = {!rst && !m_pend, m_act >= 0, ev,
               m_act == 0, m_act == W, ea, eb};
        got = {in_ready, busy, bit_valid, first, flush, a, b};
        check("outs", 32'(got), 32'(exp));
    endtask

    task automatic adder();
        if (bit_valid === 1'b1) begin
            if (idx < W) res[idx] = a ^ b ^ c;
            c = (a & b) | (c & (a ^ b));
            idx++;
        end
        if (flush === 1'b1) begin
            res[W] = c;
            check("sumq", sumq.size(), 1);
            if (sumq.size() > 0) begin
                check("sum", 32'(res), 32'(sumq.pop_front()));
            end
            c   = 1'b0;
            idx = 0;
            res = '0;
        end
    endtask

    task automatic cyc(input bit r, input bit v,
                       input logic [W-1:0] xa,
                       input logic [W-1:0] xb);
        rst      = r;
        in_valid = v;
        op_a     = xa;
        op_b     = xb;
        @(posedge clk);
        model_edge(r, v, xa, xb);
        @(negedge clk);
        compare();
        adder();
        if (busy === 1'b1) busy_n++;
        if (bit_valid === 1'b1) bv_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        int k;

        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 8'h5A, 8'hA5);

        cyc(1'b0, 1'b1, 8'h0F, 8'h01);
        idle(11);

        cyc(1'b0, 1'b1, 8'hFF, 8'h01);
        idle(11);

        busy_n = 0;
        cyc(1'b0, 1'b1, 8'h12, 8'h34);
        check("take1", in_ready, 0);
        k = 0;
        do begin
            cyc(1'b0, 1'b1, 8'h80, 8'h80);
            k++;
        end while (!m_took && k < 20);
        check("take2", m_took, 1);
        idle(20);
        check("busy_n", busy_n, 18);

        cyc(1'b0, 1'b1, 8'hAA, 8'h55);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, W'($urandom), W'($urandom));
        end
        idle(14);

        cyc(1'b0, 1'b1, W'($urandom), W'($urandom));
        k = 0;
        do begin
            cyc(1'b0, 1'b1, W'($urandom), W'($urandom));
            k++;
        end while (!m_took && k < 20);
        check("pend", m_took, 1);
        k = 0;
        while (m_act != 4 && k < 20) begin
            cyc(1'b0, 1'b0, '0, '0);
            k++;
        end
        check("at4", m_act, 4);
        cyc(1'b1, 1'b1, W'($urandom), W'($urandom));
        check("rst_busy", busy, 0);
        check("rst_rdy", in_ready, 0);
        bv_n = 0;
        cyc(1'b0, 1'b0, '0, '0);
        check("post_busy", busy, 0);
        check("post_rdy", in_ready, 1);
        idle(12);
        check("post_bits", bv_n, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 96) == 0,
                $urandom_range(0, 2) == 0,
                W'($urandom), W'($urandom));
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
